// File: rtl/ppu_pkg.sv
// Shared constants and state encodings for the PPU scanline double buffer.
package ppu_pkg;

  localparam int unsigned LINE_PIXELS = 256;
  localparam int unsigned PixW        = 6;
  localparam logic [5:0]  BLACK_IDX   = 6'h0F;

  typedef enum logic [1:0] {BkEmpty, BkFull, BkDrain} bank_st_e;
  typedef enum logic [0:0] {WrFill, WrWait} wr_st_e;
  typedef enum logic [1:0] {RdIdle, RdDrain, RdUnder} rd_st_e;

  function automatic logic [1:0] full_count(input bank_st_e b0, input bank_st_e b1);
    return {1'b0, b0 == BkFull} + {1'b0, b1 == BkFull};
  endfunction

endpackage

// File: rtl/ppu_line_ram.sv
// Simple dual-port line store: one write port, one registered read port, no array reset.
module ppu_line_ram
  import ppu_pkg::*;
#(
  parameter int unsigned Depth = 2 * LINE_PIXELS,
  parameter int unsigned Width = PixW,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ppu_linebuf_ctrl.sv
// Two-bank scanline buffer between the PPU pixel writer and the VGA pixel reader.
module ppu_linebuf_ctrl #(
  parameter int unsigned LINE_PIXELS = ppu_pkg::LINE_PIXELS,
  parameter logic [5:0]  BLACK_IDX   = ppu_pkg::BLACK_IDX
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_start_i,
  input  logic       wr_valid_i,
  input  logic [5:0] wr_data_i,
  output logic       wr_ready_o,
  input  logic       rd_en_i,
  output logic [5:0] rd_data_o,
  output logic       underrun_o,
  input  logic       underrun_clr_i,
  output logic [1:0] lines_full_o
);
  import ppu_pkg::*;

  localparam int unsigned PtrW  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int unsigned AddrW = $clog2(2 * LINE_PIXELS);
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(LINE_PIXELS - 1);
  localparam logic [AddrW-1:0] BankOff = AddrW'(LINE_PIXELS);

  wr_st_e          wr_st_q, wr_st_d;
  rd_st_e          rd_st_q, rd_st_d;
  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  logic            wb_q, wb_d, rb_q, rb_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            underrun_q, underrun_d;
  logic [1:0]      lines_full_q, lines_full_d;
  logic            src_black_q, src_black_d;

  logic       wr_acc, wr_last, rd_go, rd_last, rd_from_ram, underrun_set;
  logic [5:0] ram_rdata;

  // frame_start masks every other event so the resync is clean.
  assign wr_acc       = wr_valid_i & (wr_st_q == WrFill) & ~frame_start_i;
  assign wr_last      = wr_acc & (wr_ptr_q == LastPtr);
  assign rd_go        = rd_en_i & ~frame_start_i;
  assign rd_last      = rd_ptr_q == LastPtr;
  assign rd_from_ram  = (rd_st_q == RdDrain) || ((rd_st_q == RdIdle) && (bank_q[rb_q] == BkFull));
  assign underrun_set = rd_go & (rd_st_q == RdIdle) & (bank_q[rb_q] != BkFull);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_st_q      <= WrFill;
      rd_st_q      <= RdIdle;
      bank_q[0]    <= BkEmpty;
      bank_q[1]    <= BkEmpty;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      underrun_q   <= 1'b0;
      lines_full_q <= '0;
      src_black_q  <= 1'b1;
    end else begin
      wr_st_q      <= wr_st_d;
      rd_st_q      <= rd_st_d;
      bank_q       <= bank_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      underrun_q   <= underrun_d;
      lines_full_q <= lines_full_d;
      src_black_q  <= src_black_d;
    end
  end

  always_comb begin
    bank_d      = bank_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underrun_d  = underrun_q;
    src_black_d = src_black_q;
    if (frame_start_i) begin
      bank_d[0] = BkEmpty;
      bank_d[1] = BkEmpty;
      wb_d      = 1'b0;
      rb_d      = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (wr_acc) begin
        if (wr_last) begin
          bank_d[wb_q] = BkFull;
          wr_ptr_d     = '0;
          wb_d         = ~wb_q;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      if (rd_go) begin
        rd_ptr_d    = rd_last ? '0 : rd_ptr_q + 1'b1;
        src_black_d = ~rd_from_ram;
        if ((rd_st_q == RdIdle) && (bank_q[rb_q] == BkFull)) bank_d[rb_q] = BkDrain;
        if ((rd_st_q == RdDrain) && rd_last) begin
          bank_d[rb_q] = BkEmpty;
          rb_d         = ~rb_q;
        end
      end
      if (underrun_set)        underrun_d = 1'b1;
      else if (underrun_clr_i) underrun_d = 1'b0;
    end
    lines_full_d = full_count(bank_d[0], bank_d[1]);
  end

  // Looking at the next bank status lets a same-cycle release reopen the writer at once.
  always_comb begin
    wr_st_d = (bank_d[wb_d] == BkEmpty) ? WrFill : WrWait;
    rd_st_d = rd_st_q;
    unique case (rd_st_q)
      RdIdle:           if (rd_go) rd_st_d = (bank_q[rb_q] == BkFull) ? RdDrain : RdUnder;
      RdDrain, RdUnder: if (rd_go && rd_last) rd_st_d = RdIdle;
      default:          rd_st_d = RdIdle;
    endcase
    if (frame_start_i) rd_st_d = RdIdle;
  end

  always_comb begin
    wr_ready_o   = (wr_st_q == WrFill);
    rd_data_o    = src_black_q ? BLACK_IDX : ram_rdata;
    underrun_o   = underrun_q;
    lines_full_o = lines_full_q;
  end

  ppu_line_ram #(
    .Depth (2 * LINE_PIXELS),
    .Width (6)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i ((wb_q ? BankOff : '0) + AddrW'(wr_ptr_q)),
    .wdata_i (wr_data_i),
    .re_i    (rd_go & rd_from_ram),
    .raddr_i ((rb_q ? BankOff : '0) + AddrW'(rd_ptr_q)),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_ppu_linebuf_ctrl.sv
// Directed bench for ppu_linebuf_ctrl: fill/drain, backpressure, underrun, resync, async reset.
module tb_ppu_linebuf_ctrl;

  localparam int unsigned LP  = 256;
  localparam logic [5:0]  BLK = 6'h0F;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       frame_start_i;
  logic       wr_valid_i;
  logic [5:0] wr_data_i;
  logic       wr_ready_o;
  logic       rd_en_i;
  logic [5:0] rd_data_o;
  logic       underrun_o;
  logic       underrun_clr_i;
  logic [1:0] lines_full_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  ppu_linebuf_ctrl #(
    .LINE_PIXELS (LP),
    .BLACK_IDX   (BLK)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .frame_start_i  (frame_start_i),
    .wr_valid_i     (wr_valid_i),
    .wr_data_i      (wr_data_i),
    .wr_ready_o     (wr_ready_o),
    .rd_en_i        (rd_en_i),
    .rd_data_o      (rd_data_o),
    .underrun_o     (underrun_o),
    .underrun_clr_i (underrun_clr_i),
    .lines_full_o   (lines_full_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; frame_start_i = 1'b0; wr_valid_i = 1'b0; wr_data_i = '0;
    rd_en_i = 1'b0; underrun_clr_i = 1'b0;
    repeat (3) step();
    rst_ni = 1'b1;
    step();
    chk("rst_wr_ready", wr_ready_o, 1);
    chk("rst_rd_data", rd_data_o, BLK);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_lines_full", lines_full_o, 0);

    // One line of i%64, then drain it.
    for (int i = 0; i < 256; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 6'(i % 64); step();
    end
    wr_valid_i = 1'b0;
    chk("s1_lines_full", lines_full_o, 1);
    chk("s1_wr_ready", wr_ready_o, 1);
    chk("s1_rd_pre", rd_data_o, BLK);
    for (int i = 0; i < 256; i++) begin
      rd_en_i = 1'b1; step();
      chk("s1_rd_data", rd_data_o, 32'(i % 64));
    end
    rd_en_i = 1'b0; step();
    chk("s1_rd_hold", rd_data_o, 63);
    chk("s1_underrun", underrun_o, 0);
    chk("s1_lines_empty", lines_full_o, 0);

    // Two lines with no reads: writer must stall until a line drains.
    for (int i = 0; i < 512; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 6'((i * 7) % 64); step();
      if (i == 255) begin
        chk("s2_half_ready", wr_ready_o, 1);
        chk("s2_half_full", lines_full_o, 1);
      end
    end
    wr_valid_i = 1'b0;
    chk("s2_wait_ready", wr_ready_o, 0);
    chk("s2_two_full", lines_full_o, 2);
    for (int i = 0; i < 256; i++) begin
      rd_en_i = 1'b1; step();
      chk("s2_rd_data_a", rd_data_o, 32'((i * 7) % 64));
      if (i == 0 || i == 254) chk("s2_still_wait", wr_ready_o, 0);
      if (i == 255) begin
        chk("s2_reopen", wr_ready_o, 1);
        chk("s2_one_full", lines_full_o, 1);
      end
    end
    for (int i = 0; i < 256; i++) begin
      rd_en_i = 1'b1; step();
      chk("s2_rd_data_b", rd_data_o, 32'(((i + 256) * 7) % 64));
    end
    rd_en_i = 1'b0; step();
    chk("s2_lines_empty", lines_full_o, 0);

    // Underrun line, clear, then clear colliding with a new set.
    for (int i = 0; i < 256; i++) begin
      rd_en_i = 1'b1; step();
      chk("s3_black", rd_data_o, BLK);
      if (i == 0) chk("s3_underrun_set", underrun_o, 1);
    end
    rd_en_i = 1'b0; step();
    chk("s3_sticky", underrun_o, 1);
    chk("s3_no_full", lines_full_o, 0);
    underrun_clr_i = 1'b1; step();
    underrun_clr_i = 1'b0;
    chk("s3_cleared", underrun_o, 0);
    rd_en_i = 1'b1; underrun_clr_i = 1'b1; step();
    underrun_clr_i = 1'b0;
    chk("s3_set_wins", underrun_o, 1);
    for (int i = 0; i < 255; i++) step();
    rd_en_i = 1'b0;

    // Fill one bank, then drain it while filling the other in lockstep.
    for (int i = 0; i < 256; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 6'((i * 3) % 64); step();
    end
    for (int i = 0; i < 256; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 6'((i + 40) % 64); rd_en_i = 1'b1; step();
      if (i == 100) begin
        chk("s4_mid_lines", lines_full_o, 0);
        chk("s4_mid_data", rd_data_o, 32'((100 * 3) % 64));
      end
      if (i == 255) begin
        chk("s4_wr_ready", wr_ready_o, 1);
        chk("s4_lines_full", lines_full_o, 1);
        chk("s4_last_data", rd_data_o, 32'((255 * 3) % 64));
      end
    end
    wr_valid_i = 1'b0; rd_en_i = 1'b0;

    // Resync mid-frame; the in-flight write and read are dropped.
    for (int i = 0; i < 100; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 6'(i); rd_en_i = (i < 50); step();
    end
    frame_start_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 6'h2A; rd_en_i = 1'b1; step();
    frame_start_i = 1'b0; wr_valid_i = 1'b0; rd_en_i = 1'b0;
    chk("s5_lines_full", lines_full_o, 0);
    chk("s5_wr_ready", wr_ready_o, 1);
    chk("s5_underrun_kept", underrun_o, 1);
    for (int i = 0; i < 256; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 6'((i + 20) % 64); step();
    end
    chk("s5_line_full", lines_full_o, 1);
    for (int i = 0; i < 256; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 6'(63 - (i % 64)); step();
    end
    wr_valid_i = 1'b0;
    chk("s5_both_full", lines_full_o, 2);
    for (int i = 0; i < 3; i++) begin
      rd_en_i = 1'b1; step();
      chk("s5_first_read", rd_data_o, 32'(20 + i));
    end
    rd_en_i = 1'b0;
    chk("s5_draining", lines_full_o, 1);
    chk("s5_pre_rst_ready", wr_ready_o, 0);

    // Asynchronous reset mid-drain, sampled before the next clock edge.
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("s6_wr_ready", wr_ready_o, 1);
    chk("s6_rd_data", rd_data_o, BLK);
    chk("s6_lines_full", lines_full_o, 0);
    chk("s6_underrun", underrun_o, 0);
    step();
    step();
    rst_ni = 1'b1;
    step();
    chk("s6_post_ready", wr_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_linebuf_ctrl.md
PPU_LINEBUF_CTRL -- requirements
Module: ppu_linebuf_ctrl

Interface
REQ-001 Parameter LINE_PIXELS, default 256, pixels per scanline and depth of each line bank.
REQ-002 Parameter BLACK_IDX, default 6'h0F, palette index output on underrun.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 frame_start  input  1  single-cycle pulse at the start of each VGA frame; resynchronises the buffer.
REQ-006 wr_valid  input  1  PPU pixel available.
REQ-007 wr_data  input  6  PPU palette index.
REQ-008 wr_ready  output  1  controller accepts wr_data this cycle.
REQ-009 rd_en  input  1  display requests one pixel; driven by the VGA FIFO_RE.
REQ-010 rd_data  output  6  palette index for the display, registered.
REQ-011 underrun  output  1  sticky flag: a display line started with no full bank.
REQ-012 underrun_clr  input  1  synchronous clear of underrun.
REQ-013 lines_full  output  2  number of banks currently FULL (0..2).

Function
REQ-014 Two banks of LINE_PIXELS x 6 bits each; each bank status is EMPTY, FULL or DRAIN.
REQ-015 Write FSM states: FILL (wr_ready=1) and WAIT (wr_ready=0); a write is accepted when wr_valid & wr_ready.
REQ-016 In FILL, each accepted pixel is stored at wr_ptr in bank wb, and wr_ptr increments.
REQ-017 On the accept with wr_ptr==LINE_PIXELS-1, the following happen: bank wb becomes FULL, wr_ptr wraps to 0, and wb toggles.
REQ-018 After that accept, the FSM goes to FILL if the new wb is EMPTY (including when it is released in the same cycle) and to WAIT otherwise.
REQ-019 In WAIT, the FSM returns to FILL in the cycle after bank wb becomes EMPTY.
REQ-020 Read FSM states: IDLE, DRAIN, UNDER; rd_ptr counts 0..LINE_PIXELS-1 on each rd_en.
REQ-021 In IDLE, rd_en with bank rb FULL sets rb to DRAIN and moves the FSM to DRAIN.
REQ-022 In IDLE, rd_en with bank rb not FULL moves the FSM to UNDER and sets underrun.
REQ-023 In DRAIN, rd_data equals bank rb at rd_ptr one cycle after rd_en (latency 1).
REQ-024 In UNDER, rd_data equals BLACK_IDX one cycle after rd_en, and no bank is consumed.
REQ-025 The rd_en with rd_ptr==LINE_PIXELS-1 ends the line.
REQ-026 At end of a DRAIN line, bank rb becomes EMPTY, rb toggles, and the FSM returns to IDLE.
REQ-027 At end of an UNDER line, the FSM returns to IDLE and rb is unchanged.
REQ-028 rd_data holds its last value when rd_en=0.
REQ-029 When a release and a fill complete in the same cycle on different banks, both updates apply.
REQ-030 frame_start has priority over all other events in the same cycle.
REQ-031 On frame_start: both banks become EMPTY; wb, rb, wr_ptr and rd_ptr become 0; the write FSM goes to FILL and the read FSM to IDLE; an in-flight write is discarded; underrun is unchanged.
REQ-032 underrun_clr clears underrun unless a set occurs in the same cycle; a set wins.
REQ-033 lines_full is a registered count of banks in status FULL.

Reset
REQ-034 Reset sets: wr_ready=1 (FILL), read FSM IDLE, rd_data=BLACK_IDX, underrun=0, lines_full=0, both banks EMPTY, all pointers 0, wb=rb=0.
REQ-035 Reset asserted mid-line discards all buffered pixels; bank memory contents are don't-care.

Structure
REQ-036 The shared package ppu_pkg shall hold LINE_PIXELS, BLACK_IDX, and the enums for bank status, write state and read state.
REQ-037 One sub-module, ppu_line_ram, shall implement the 2*LINE_PIXELS x 6 simple dual-port RAM with registered read and no reset on the array.

Verification
REQ-038 Bench scenario: write 256 pixels with value i%64, then 256 consecutive rd_en -> rd_data sequence is 0..63 repeated, with 1-cycle latency, and underrun=0.
REQ-039 Bench scenario: write 512 pixels with no reads -> wr_ready=0 after the 512th accept, and lines_full=2; on the first rd_en of the next line, the writer stays in WAIT until that line completes, then wr_ready=1.
REQ-040 Bench scenario: rd_en with no full bank -> 256 outputs of 6'h0F and underrun=1; a later underrun_clr gives underrun=0.
REQ-041 Bench scenario: 256th write accept and 256th read of the other bank in the same cycle -> in the next cycle wr_ready=1 and lines_full=1.
REQ-042 Bench scenario: frame_start after 100 writes and 50 reads -> lines_full=0, and the next written pixel is read first.
REQ-043 Bench scenario: reset asserted asynchronously mid-DRAIN -> outputs take the reset values immediately, without waiting for a clock edge.
